// File: rtl/spram512_arb_pkg.sv
// spram512_arb_pkg: shared widths and the round-robin pick helper used by
// the spram512x32 arbiter and any other shared-resource controller.
//   SPRAM_ADDR_W / SPRAM_DATA_W / SPRAM_BE_W : default SRAM geometry
//   MAX_REQ / PTR_W                         : upper bound on requesters, pointer width
//   rr_pick(valid, ptr, n)                  : one-hot grant, first set bit at or after ptr
package spram512_arb_pkg;
  localparam int SPRAM_ADDR_W = 9;
  localparam int SPRAM_DATA_W = 32;
  localparam int SPRAM_BE_W   = 4;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Walks downward so the lowest rotated offset (closest to ptr) wins last.
  // Only the first n bits of valid participate; ptr must be < n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] gnt;
    int                 idx;
    gnt = '0;
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[2:0]]) begin
          gnt            = '0;
          gnt[idx[2:0]]  = 1'b1;
        end
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/spram512_arb_if.sv
// spram512_arb_if: requester-side bus of the spram512 arbiter.
//   req_valid/req_ready/req_we : per-requester handshake and direction
//   req_addr/req_wdata/req_be  : flat packed per-requester fields, requester i at [i*W +: W]
//   rsp_valid                  : one-hot read strobe
//   rsp_rdata                  : shared read data, qualified by rsp_valid
// master = requesters, slave = arbiter.
interface spram512_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*BE_W-1:0]   req_be;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram512_arb_rr_arb_onehot.sv
// rr_arb_onehot: combinational round-robin one-hot grant with registered
// rotating pointer.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   valid    : N request bits
//   advance  : a grant was consumed this cycle; pointer moves past the winner
//   grant    : one-hot or zero
module rr_arb_onehot
  import spram512_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  input  logic         advance,
  output logic [N-1:0] grant
);
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick_hi;

  assign pick           = rr_pick(MAX_REQ'(valid), ptr, N);
  assign grant          = pick[N-1:0];
  assign unused_pick_hi = ^pick;

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++)
      if (grant[i]) ptr_nxt = (i == N-1) ? '0 : PTR_W'(i+1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/spram512_arb.sv
// spram512_arb: round-robin arbiter/sequencer sharing one std_spram512x32
// (active-low CEB/WEB, byte enables, 1-cycle read latency) among NUM_REQ
// requesters.
//   clk, rst      : clock (also the SRAM clock), async active-high reset
//   bus (slave)   : requester valid/ready channel and one-hot read response
//   mem_ceb/web   : SRAM chip/write enables, active-low
//   mem_a/d/be    : SRAM address, write data, byte enables
//   mem_q         : SRAM read data
// Build option SPRAM512_ARB_RSP_REG_EN: adds a register stage on
// rsp_valid/rsp_rdata (read latency 2, rsp_rdata flop-driven).
module spram512_arb
  import spram512_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SPRAM_ADDR_W,
  parameter int DATA_W  = SPRAM_DATA_W,
  parameter int BE_W    = SPRAM_BE_W
) (
  input  logic              clk,
  input  logic              rst,
  spram512_arb_if.slave     bus,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_q
);
`ifdef SPRAM512_ARB_RSP_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [NUM_REQ-1:0] valid_g, grant, rd_tag;
  logic               fire, g_we;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [BE_W-1:0]    g_be;

  // One-hot read tag per stage; [STAGES] drives rsp_valid.
  logic [STAGES:1][NUM_REQ-1:0] vld_pipe;

  // Nothing is granted while reset is held, so the SRAM stays untouched.
  assign valid_g = bus.req_valid & {NUM_REQ{~rst}};

  rr_arb_onehot #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_g),
    .advance (fire),
    .grant   (grant)
  );

  assign bus.req_ready = grant;
  assign fire          = |grant;

  // One-hot AND-OR mux; all-zero when idle so idle pins read as 0.
  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_we    = bus.req_we[i];
        g_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        g_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        g_be    = bus.req_be[i*BE_W +: BE_W];
      end
    end
  end

  assign mem_ceb = ~fire;
  assign mem_web = ~(fire & g_we);
  assign mem_a   = g_addr;
  assign mem_d   = g_wdata;
  assign mem_be  = g_we ? g_be : '0;

  assign rd_tag = (fire & ~g_we) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_tag;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign bus.rsp_valid = vld_pipe[STAGES];

`ifdef SPRAM512_ARB_RSP_REG_EN
  logic [DATA_W-1:0] rdata_q;

  // mem_q is valid while stage 1 holds a tag; capture it alongside stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= (|vld_pipe[1]) ? mem_q : '0;
  end

  assign bus.rsp_rdata = rdata_q;
`else
  assign bus.rsp_rdata = (|vld_pipe[1]) ? mem_q : '0;
`endif
endmodule

// File: tb/tb_spram512_arb.sv
// tb_spram512_arb: directed bench for spram512_arb with a behavioural
// spram512x32 model; reads push expected responses into a scoreboard that a
// negedge monitor pops and compares (strobe, data, arrival cycle).
module tb_spram512_arb;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef SPRAM512_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          preload = 1'b0;
  logic          mem_ceb, mem_web;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;
  logic [BW-1:0] mem_be;

  spram512_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus();

  spram512_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mem_ceb (mem_ceb),
    .mem_web (mem_web),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_be  (mem_be),
    .mem_q   (mem_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled write, registered read, q holds otherwise.
  logic [DW-1:0] sram [0:511];
  always @(posedge clk) begin
    if (preload) begin
      sram[9'h1A5] <= 32'hDEADBEEF;
      sram[9'h010] <= 32'hAAAAAAAA;
      sram[9'h100] <= 32'h5A5A0000;
      sram[9'h101] <= 32'h5A5A0001;
      sram[9'h102] <= 32'h5A5A0002;
      sram[9'h103] <= 32'h5A5A0003;
    end else if (!mem_ceb) begin
      if (!mem_web) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
      end else begin
        mem_q <= sram[mem_a];
      end
    end
  end

  typedef struct {
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [N-1:0] oh, input logic [DW-1:0] data);
    exp_t e;
    e.oh = oh; e.data = data; e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_be[i*BW +: BW]    = be;
  endtask

  task automatic clr_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic pins(input string nm, input logic [N-1:0] rdy, input logic ceb,
                      input logic web, input logic [BW-1:0] be);
    chk({nm, "_ready"}, 64'(bus.req_ready), 64'(rdy));
    chk({nm, "_ceb"},   64'(mem_ceb),       64'(ceb));
    chk({nm, "_web"},   64'(mem_web),       64'(web));
    chk({nm, "_be"},    64'(mem_be),        64'(be));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle either a response matches the scoreboard head or
  // rsp_rdata is zero and nothing is overdue.
  always @(negedge clk) begin
    exp_t e;
    if (|bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.oh));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
        chk("rsp_cycle", 64'(cyc),           64'(e.due));
      end
    end else begin
      chk("rsp_rdata_idle", 64'(bus.rsp_rdata), 64'(0));
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 64'(bus.rsp_valid), 64'(e.oh));
      end
    end
  end

  initial begin
    logic [N-1:0] oh;
    logic [N-1:0] t4_rdy [3];
    logic [DW-1:0] t4_dat [3];
    t4_rdy[0] = 4'b0001; t4_dat[0] = 32'hDEADBEEF;
    t4_rdy[1] = 4'b0100; t4_dat[1] = 32'hAA22AA44;
    t4_rdy[2] = 4'b0001; t4_dat[2] = 32'hDEADBEEF;

    // Reset state, with a request pending to show the SRAM is left alone.
    clr_all();
    preload = 1'b1;
    set_req(0, 1'b1, 1'b0, 9'h1A5, '0, '0);
    @(negedge clk);
    pins("reset", 4'b0000, 1'b1, 1'b1, 4'b0000);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    tick();
    preload = 1'b0;
    rst     = 1'b0;
    clr_all();
    tick();

    // 1: single read by requester 0.
    set_req(0, 1'b1, 1'b0, 9'h1A5, '0, 4'b1111);
    @(negedge clk);
    pins("t1", 4'b0001, 1'b0, 1'b1, 4'b0000);
    chk("t1_addr", 64'(mem_a), 64'(9'h1A5));
    push(4'b0001, 32'hDEADBEEF);
    tick();
    clr_all();

    // 2: byte write then read-back by requester 2 (ptr now 1).
    set_req(2, 1'b1, 1'b1, 9'h010, 32'h11223344, 4'b0101);
    @(negedge clk);
    pins("t2w", 4'b0100, 1'b0, 1'b0, 4'b0101);
    chk("t2w_d", 64'(mem_d), 64'(32'h11223344));
    tick();
    set_req(2, 1'b1, 1'b0, 9'h010, 32'h11223344, 4'b0101);
    @(negedge clk);
    pins("t2r", 4'b0100, 1'b0, 1'b1, 4'b0000);
    push(4'b0100, 32'hAA22AA44);
    tick();
    clr_all();

    // 4: ptr=3, requesters 0 and 2 valid -> 0, 2, 0.
    set_req(0, 1'b1, 1'b0, 9'h1A5, 32'h01010101, 4'b1111);
    set_req(2, 1'b1, 1'b0, 9'h010, 32'h02020202, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_ready", 64'(bus.req_ready), 64'(t4_rdy[k]));
      push(t4_rdy[k], t4_dat[k]);
      tick();
    end
    // Idle with stale fields on the bus: pins must still read zero.
    bus.req_valid = '0;
    @(negedge clk);
    pins("idle", 4'b0000, 1'b1, 1'b1, 4'b0000);
    chk("idle_a", 64'(mem_a), 64'(0));
    chk("idle_d", 64'(mem_d), 64'(0));
    tick();
    clr_all();

    // 5: reset in the cycle after a read fire drops the response.
    set_req(2, 1'b1, 1'b0, 9'h010, '0, '0);
    @(negedge clk);
    chk("t5_ready", 64'(bus.req_ready), 64'(4'b0100));
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_all();
    set_req(0, 1'b1, 1'b0, 9'h1A5, '0, '0);
    #1;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t5_ceb", 64'(mem_ceb), 64'(1));
    chk("t5_ready_rst", 64'(bus.req_ready), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    clr_all();
    @(negedge clk);
    chk("t5_rsp_after", 64'(bus.rsp_valid), 64'(0));
    tick();

    // 3: all four hold reads for 8 cycles from reset -> 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(9'h100 + i), '0, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      oh = '0;
      oh[k % 4] = 1'b1;
      chk("t3_ready", 64'(bus.req_ready), 64'(oh));
      push(oh, 32'h5A5A0000 + DW'(k % 4));
      tick();
    end
    clr_all();

    // 6: back-to-back reads, a write right behind, then read-after-write.
    set_req(1, 1'b1, 1'b0, 9'h1A5, '0, '0);
    @(negedge clk);
    chk("t6_ready_a", 64'(bus.req_ready), 64'(4'b0010));
    push(4'b0010, 32'hDEADBEEF);
    tick();
    clr_all();
    set_req(3, 1'b1, 1'b0, 9'h101, '0, '0);
    @(negedge clk);
    chk("t6_ready_b", 64'(bus.req_ready), 64'(4'b1000));
    push(4'b1000, 32'h5A5A0001);
    tick();
    clr_all();
    set_req(0, 1'b1, 1'b1, 9'h1A5, 32'h0BADF00D, 4'b1111);
    @(negedge clk);
    pins("t6w", 4'b0001, 1'b0, 1'b0, 4'b1111);
    tick();
    set_req(0, 1'b1, 1'b0, 9'h1A5, '0, '0);
    @(negedge clk);
    chk("t6_ready_raw", 64'(bus.req_ready), 64'(4'b0001));
    push(4'b0001, 32'h0BADF00D);
    tick();
    clr_all();

    // Drain; any response never delivered is flagged by the monitor.
    repeat (5) tick();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
